hero_write_arb: RTL and testbench

Round-robin arbiter sharing the single hero write bus among `NUM_REQ` requesters. Each requester drives a `CYCLE_TYPE_E`-style stream (IDLE/VALID/DONE); the arbiter locks onto one requester for a full packet (through its DONE beat), forwards the beats through one output register stage, and then rotates priority. It sits between the write-initiating agents and the hero bus driver.

---
 rtl/hero_write_arb_pkg.sv | 28 ++
 rtl/hero_write_arb_rr_pick.sv | 36 +++
 rtl/hero_write_arb.sv | 196 +++++++++++++++++++
 tb/tb_hero_write_arb.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hero_write_arb_pkg.sv
// Shared types for the hero write arbiter: bus cycle type, beat struct,
// arbiter FSM states and a small cycle-type helper.
package hero_write_arb_pkg;

    localparam int HERO_WIDTH = 36;

    typedef enum logic [1:0] {
        CYC_IDLE  = 2'd0,
        CYC_VALID = 2'd1,
        CYC_DONE  = 2'd2
    } cycle_type_e;

    typedef struct packed {
        cycle_type_e             cyc;
        logic [HERO_WIDTH-1:0]   wdat;
    } hero_write_t;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } hero_arb_state_e;

    // VALID and DONE carry a beat; IDLE and the illegal encoding 3 do not.
    function automatic logic cyc_is_active(input logic [1:0] cyc);
        return (cyc == 2'd1) || (cyc == 2'd2);
    endfunction

endpackage

// File: rtl/hero_write_arb_rr_pick.sv
// Combinational round-robin first-one finder: returns the first set bit of
// `active` at or after `ptr`, wrapping modulo N. Reusable by other arbiters.
module rr_pick #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] active,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] idx,
    output logic         found
);

    logic [W:0] cand_s;

    // Scan offsets 0..N-1 from the pointer; the first hit wins.
    always_comb begin
        idx    = '0;
        found  = 1'b0;
        cand_s = '0;
        for (int k = 0; k < N; k++) begin
            cand_s = {1'b0, ptr} + (W+1)'(k);
            if (cand_s >= (W+1)'(N)) begin
                cand_s = cand_s - (W+1)'(N);
            end else begin
                cand_s = cand_s;
            end
            if (!found && active[cand_s[W-1:0]]) begin
                found = 1'b1;
                idx   = cand_s[W-1:0];
            end else begin
                found = found;
            end
        end
    end

endmodule

// File: rtl/hero_write_arb.sv
// Round-robin arbiter for the shared hero write bus. Locks onto one requester
// for a whole packet (through its DONE beat), forwards beats through a single
// output register and then rotates priority.
// Optional lock watchdog: define HERO_WRITE_ARB_WATCHDOG_EN.
module hero_write_arb #(
    parameter int NUM_REQ      = 4,
    parameter int HERO_WIDTH   = hero_write_arb_pkg::HERO_WIDTH,
    parameter int LOCK_TIMEOUT = 256
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [2*NUM_REQ-1:0]          req_cycle_type,
    input  logic [NUM_REQ*HERO_WIDTH-1:0] req_wdat,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [1:0]                    hero_cycle_type,
    output logic [HERO_WIDTH-1:0]         hero_wdat,
    output logic                          hero_clk_en,
    input  logic                          hero_ready,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          err_timeout
);

    import hero_write_arb_pkg::*;

    localparam int GW = $clog2(NUM_REQ);

    hero_arb_state_e          state_q, state_d;
    logic [GW-1:0]            grant_q, grant_d;
    logic [GW-1:0]            ptr_q, ptr_d;
    cycle_type_e              out_cyc_q, out_cyc_d;
    logic [HERO_WIDTH-1:0]    out_wdat_q, out_wdat_d;

    logic [NUM_REQ-1:0]       active_s;
    logic [NUM_REQ-1:0]       req_ready_s;
    logic [1:0]               own_cyc_s;
    logic [HERO_WIDTH-1:0]    own_wdat_s;
    logic                     own_active_s;
    logic                     out_valid_s;
    logic                     out_free_s;
    logic                     accept_s;
    logic                     wd_expired_s;
    logic                     force_done_s;
    logic [GW-1:0]            grant_inc_s;
    logic [GW-1:0]            pick_idx_s;
    logic                     pick_found_s;

    rr_pick #(
        .N (NUM_REQ),
        .W (GW)
    ) u_rr_pick (
        .active (active_s),
        .ptr    (ptr_q),
        .idx    (pick_idx_s),
        .found  (pick_found_s)
    );

    // Decode per-requester activity and mux out the current owner's beat.
    always_comb begin
        active_s   = '0;
        own_cyc_s  = 2'd0;
        own_wdat_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            active_s[i] = cyc_is_active(req_cycle_type[2*i +: 2]);
            if (grant_q == GW'(i)) begin
                own_cyc_s  = req_cycle_type[2*i +: 2];
                own_wdat_s = req_wdat[HERO_WIDTH*i +: HERO_WIDTH];
            end else begin
                own_cyc_s  = own_cyc_s;
                own_wdat_s = own_wdat_s;
            end
        end
        own_active_s = cyc_is_active(own_cyc_s);
        out_valid_s  = (out_cyc_q != CYC_IDLE);
        out_free_s   = ~out_valid_s | hero_ready;
        grant_inc_s  = (grant_q == GW'(NUM_REQ-1)) ? '0 : grant_q + GW'(1);
    end

`ifdef HERO_WRITE_ARB_WATCHDOG_EN
    localparam int WD_W = $clog2(LOCK_TIMEOUT + 1);

    logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
    logic            err_timeout_q, err_timeout_d;

    // Count consecutive locked cycles without an accepted beat; saturate at the limit.
    always_comb begin
        wd_expired_s  = (wd_cnt_q == WD_W'(LOCK_TIMEOUT));
        err_timeout_d = force_done_s;
        if ((state_q != ARB_LOCKED) || accept_s || force_done_s) begin
            wd_cnt_d = '0;
        end else if (!wd_expired_s) begin
            wd_cnt_d = wd_cnt_q + WD_W'(1);
        end else begin
            wd_cnt_d = wd_cnt_q;
        end
    end

    // Watchdog counter and one-cycle timeout pulse register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt_q      <= '0;
            err_timeout_q <= 1'b0;
        end else begin
            wd_cnt_q      <= wd_cnt_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    assign err_timeout = err_timeout_q;
`else
    // Without the watchdog a lock is held until the owner's DONE.
    assign wd_expired_s = 1'b0;
    assign err_timeout  = 1'b0;

    logic unused_cfg_s;
    assign unused_cfg_s = ^LOCK_TIMEOUT;
`endif

    // Arbiter FSM: arbitrate in ARB_IDLE, forward the owner's beats in ARB_LOCKED.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        ptr_d        = ptr_q;
        req_ready_s  = '0;
        accept_s     = 1'b0;
        force_done_s = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (pick_found_s) begin
                    grant_d = pick_idx_s;
                    state_d = ARB_LOCKED;
                end else begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_LOCKED: begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    req_ready_s[i] = (grant_q == GW'(i)) & out_free_s & ~wd_expired_s;
                end
                accept_s     = out_free_s & own_active_s & ~wd_expired_s;
                force_done_s = wd_expired_s & out_free_s;
                if ((accept_s && (own_cyc_s == CYC_DONE)) || force_done_s) begin
                    state_d = ARB_IDLE;
                    ptr_d   = grant_inc_s;
                end else begin
                    state_d = ARB_LOCKED;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // Output register: load accepted or forced beats, hold under backpressure, drain on ready.
    always_comb begin
        out_cyc_d  = out_cyc_q;
        out_wdat_d = out_wdat_q;
        if (accept_s) begin
            out_cyc_d  = cycle_type_e'(own_cyc_s);
            out_wdat_d = own_wdat_s;
        end else if (force_done_s) begin
            out_cyc_d  = CYC_DONE;
            out_wdat_d = '0;
        end else if (hero_ready) begin
            out_cyc_d  = CYC_IDLE;
            out_wdat_d = '0;
        end else begin
            out_cyc_d  = out_cyc_q;
            out_wdat_d = out_wdat_q;
        end
    end

    // State, grant, round-robin pointer and output beat registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ARB_IDLE;
            grant_q    <= '0;
            ptr_q      <= '0;
            out_cyc_q  <= CYC_IDLE;
            out_wdat_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            ptr_q      <= ptr_d;
            out_cyc_q  <= out_cyc_d;
            out_wdat_q <= out_wdat_d;
        end
    end

    assign req_ready       = req_ready_s;
    assign hero_cycle_type = out_cyc_q;
    assign hero_wdat       = out_wdat_q;
    assign hero_clk_en     = out_valid_s;
    assign grant_id        = grant_q;

endmodule

// File: tb/tb_hero_write_arb.sv
// Directed bench for hero_write_arb: single packet, contention, backpressure,
// owner bubble, reset mid-packet and (with HERO_WRITE_ARB_WATCHDOG_EN) the watchdog.
module tb_hero_write_arb;

    localparam int NUM_REQ = 4;
    localparam int HW      = 36;
`ifdef HERO_WRITE_ARB_WATCHDOG_EN
    localparam int LT = 8;
`else
    localparam int LT = 256;
`endif

    localparam logic [1:0] IDL = 2'd0;
    localparam logic [1:0] VLD = 2'd1;
    localparam logic [1:0] DN  = 2'd2;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic [2*NUM_REQ-1:0]   req_cycle_type = '0;
    logic [NUM_REQ*HW-1:0]  req_wdat = '0;
    logic [NUM_REQ-1:0]     req_ready;
    logic [1:0]             hero_cycle_type;
    logic [HW-1:0]          hero_wdat;
    logic                   hero_clk_en;
    logic                   hero_ready = 1'b1;
    logic [1:0]             grant_id;
    logic                   err_timeout;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    hero_write_arb #(
        .NUM_REQ      (NUM_REQ),
        .HERO_WIDTH   (HW),
        .LOCK_TIMEOUT (LT)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_cycle_type  (req_cycle_type),
        .req_wdat        (req_wdat),
        .req_ready       (req_ready),
        .hero_cycle_type (hero_cycle_type),
        .hero_wdat       (hero_wdat),
        .hero_clk_en     (hero_clk_en),
        .hero_ready      (hero_ready),
        .grant_id        (grant_id),
        .err_timeout     (err_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [1:0] cyc, input logic [HW-1:0] d);
        chk({tag, "_cyc"}, 64'(hero_cycle_type), 64'(cyc));
        chk({tag, "_wdat"}, 64'(hero_wdat), 64'(d));
        chk({tag, "_en"}, 64'(hero_clk_en), 64'(cyc != IDL));
    endtask

    task automatic set_req(input int i, input logic [1:0] c, input logic [HW-1:0] d);
        req_cycle_type[2*i +: 2] = c;
        req_wdat[HW*i +: HW]     = d;
    endtask

    // Advance to just after the next rising edge.
    task automatic nxt();
        @(posedge clk);
        #2;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk_out(tag, IDL, '0);
        chk({tag, "_rdy"}, 64'(req_ready), 64'(4'b0000));
        chk({tag, "_gnt"}, 64'(grant_id), 64'd0);
        chk({tag, "_err"}, 64'(err_timeout), 64'd0);
    endtask

    initial begin
        // Reset state
        #3;
        chk_reset_vals("rst");
        nxt();
        rst_n = 1'b1;

        // Single requester: VALID 1, VALID 2, DONE 3 from cycle 0
        set_req(0, VLD, 36'h1); #1;
        chk("t1_c0_rdy", 64'(req_ready), 64'(4'b0000));
        nxt(); #1;
        chk("t1_c1_gnt", 64'(grant_id), 64'd0);
        chk("t1_c1_rdy", 64'(req_ready), 64'(4'b0001));
        chk_out("t1_c1", IDL, '0);
        nxt(); set_req(0, VLD, 36'h2); #1;
        chk_out("t1_c2", VLD, 36'h1);
        chk("t1_c2_rdy", 64'(req_ready), 64'(4'b0001));
        nxt(); set_req(0, DN, 36'h3); #1;
        chk_out("t1_c3", VLD, 36'h2);
        nxt(); set_req(0, IDL, '0); #1;
        chk_out("t1_c4", DN, 36'h3);
        chk("t1_c4_rdy", 64'(req_ready), 64'(4'b0000));
        nxt(); #1;
        chk_out("t1_c5", IDL, '0);

        // Contention: req1 and req3 active at reset release, pointer 0
        rst_n = 1'b0; #1;
        chk_reset_vals("rst2");
        nxt();
        rst_n = 1'b1;
        set_req(1, VLD, 36'h11);
        set_req(3, DN, 36'h31);
        nxt(); #1;
        chk("t2_c1_gnt", 64'(grant_id), 64'd1);
        chk("t2_c1_rdy", 64'(req_ready), 64'(4'b0010));
        nxt(); set_req(1, DN, 36'h12); #1;
        chk_out("t2_c2", VLD, 36'h11);
        nxt(); set_req(1, IDL, '0); #1;
        chk_out("t2_c3", DN, 36'h12);
        chk("t2_c3_gnt", 64'(grant_id), 64'd1);
        chk("t2_c3_rdy", 64'(req_ready), 64'(4'b0000));
        nxt(); #1;
        chk("t2_c4_gnt", 64'(grant_id), 64'd3);
        chk("t2_c4_rdy", 64'(req_ready), 64'(4'b1000));
        chk_out("t2_c4", IDL, '0);
        nxt(); set_req(3, IDL, '0); #1;
        chk_out("t2_c5", DN, 36'h31);
        nxt(); #1;
        chk_out("t2_c6", IDL, '0);

        // Backpressure; req0 and req3 both active confirms the pointer wrapped to 0
        set_req(0, VLD, 36'hA1);
        set_req(3, DN, 36'h3F);
        nxt(); #1;
        chk("t3_c7_gnt", 64'(grant_id), 64'd0);
        chk("t3_c7_rdy", 64'(req_ready), 64'(4'b0001));
        nxt(); set_req(0, VLD, 36'hA2); hero_ready = 1'b0; #1;
        chk_out("t3_c8", VLD, 36'hA1);
        chk("t3_c8_rdy", 64'(req_ready), 64'(4'b0000));
        for (int k = 0; k < 2; k++) begin
            nxt(); #1;
            chk_out("t3_hold", VLD, 36'hA1);
            chk("t3_hold_rdy", 64'(req_ready), 64'(4'b0000));
        end
        nxt(); hero_ready = 1'b1; #1;
        chk_out("t3_c11", VLD, 36'hA1);
        chk("t3_c11_rdy", 64'(req_ready), 64'(4'b0001));
        nxt(); set_req(0, DN, 36'hA3); #1;
        chk_out("t3_c12", VLD, 36'hA2);
        nxt(); set_req(0, IDL, '0); #1;
        chk_out("t3_c13", DN, 36'hA3);
        nxt(); #1;
        chk("t3_c14_gnt", 64'(grant_id), 64'd3);
        chk("t3_c14_rdy", 64'(req_ready), 64'(4'b1000));
        chk_out("t3_c14", IDL, '0);
        nxt(); set_req(3, IDL, '0); #1;
        chk_out("t3_c15", DN, 36'h3F);

        // Bubble: owner req1 goes IDLE for 2 cycles while req2 waits
        nxt();
        set_req(1, VLD, 36'hB1);
        set_req(2, DN, 36'hC2); #1;
        chk_out("t4_c16", IDL, '0);
        nxt(); #1;
        chk("t4_c17_gnt", 64'(grant_id), 64'd1);
        nxt(); set_req(1, IDL, '0); #1;
        chk_out("t4_c18", VLD, 36'hB1);
        chk("t4_c18_rdy", 64'(req_ready), 64'(4'b0010));
        nxt(); #1;
        chk_out("t4_c19", IDL, '0);
        chk("t4_c19_gnt", 64'(grant_id), 64'd1);
        chk("t4_c19_rdy", 64'(req_ready), 64'(4'b0010));
        nxt(); set_req(1, VLD, 36'hB2); #1;
        chk("t4_c20_gnt", 64'(grant_id), 64'd1);
        nxt(); set_req(1, DN, 36'hB3); #1;
        chk_out("t4_c21", VLD, 36'hB2);
        nxt(); set_req(1, IDL, '0); #1;
        chk_out("t4_c22", DN, 36'hB3);
        chk("t4_c22_gnt", 64'(grant_id), 64'd1);
        nxt(); #1;
        chk("t4_c23_gnt", 64'(grant_id), 64'd2);
        chk("t4_c23_rdy", 64'(req_ready), 64'(4'b0100));
        nxt(); set_req(2, IDL, '0); #1;
        chk_out("t4_c24", DN, 36'hC2);

        // Reset mid-packet; pointer was 3 before reset
        nxt(); set_req(0, VLD, 36'hD1); #1;
        chk_out("t5_c25", IDL, '0);
        nxt(); #1;
        chk("t5_c26_gnt", 64'(grant_id), 64'd0);
        nxt(); set_req(0, VLD, 36'hD2); #1;
        chk_out("t5_c27", VLD, 36'hD1);
        nxt(); #1;
        chk_out("t5_c28", VLD, 36'hD2);
        rst_n = 1'b0; #1;
        chk_reset_vals("t5_rst");
        set_req(0, IDL, '0);
        nxt();
        rst_n = 1'b1;
        set_req(1, DN, 36'hE1);
        set_req(3, DN, 36'hE3);
        nxt(); #1;
        chk("t5_ptr0_gnt", 64'(grant_id), 64'd1);
        chk("t5_err", 64'(err_timeout), 64'd0);

`ifdef HERO_WRITE_ARB_WATCHDOG_EN
        // Watchdog: owner stalls after one VALID beat
        begin
            int n_err;
            int n_forced;
            int saw_g1;
            n_err = 0; n_forced = 0; saw_g1 = 0;
            set_req(1, IDL, '0); set_req(3, IDL, '0);
            rst_n = 1'b0;
            nxt();
            rst_n = 1'b1;
            set_req(0, VLD, 36'hF1);
            set_req(1, DN, 36'hF2);
            nxt();
            nxt(); set_req(0, IDL, '0);
            for (int k = 0; k < 30; k++) begin
                #1;
                if (err_timeout) n_err++;
                if ((hero_cycle_type == DN) && (hero_wdat == '0)) n_forced++;
                if ((grant_id == 2'd1) && (n_err > 0)) saw_g1 = 1;
                nxt();
            end
            chk("wd_err_pulses", 64'(n_err), 64'd1);
            chk("wd_forced_done", 64'(n_forced), 64'd1);
            chk("wd_next_grant", 64'(saw_g1), 64'd1);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
